// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the byte-serial memory arbiter
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Size code 3 is treated as a full word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request after last
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        last,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PW-1:0]        grant_idx,
  output logic                 any
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // Scan starting one past the previous winner so it is considered last.
    for (int off = 1; off <= NUM_PORTS; off++) begin
      idx = (int'(last) + off) % NUM_PORTS;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-port round-robin controller for a byte-serial 8-bit memory bus
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int                   NUM_PORTS  = 3,
  parameter logic [NUM_PORTS-1:0] FLUSH_MASK = NUM_PORTS'(3'b011),
  parameter logic [1:0]           IO_HI      = IO_ADDR_HI
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush,
  input  logic [NUM_PORTS-1:0]   req_en,
  input  logic [32*NUM_PORTS-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]   req_write,
  input  logic [2*NUM_PORTS-1:0] req_size,
  input  logic [NUM_PORTS-1:0]   req_signed,
  input  logic [32*NUM_PORTS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]   resp_rdy,
  output logic [32*NUM_PORTS-1:0] resp_data,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr,
  input  logic                   io_buffer_full
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_t state, state_n;

  logic [2:0]    cnt;
  logic [PW-1:0] rr_last;
  logic [PW-1:0] cur_port;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [1:0]    cur_size;
  logic          cur_signed;
  logic          cur_write;
  logic [31:0]   rbuf;
  logic [31:0]   held [NUM_PORTS];

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] grant;
  logic [PW-1:0]        grant_idx;
  logic                 grant_any;

  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_size;
  logic        sel_signed;
  logic        sel_write;

  logic [2:0]  nbytes;
  logic [1:0]  rd_idx;
  logic        kill;
  logic        stall;
  logic        mem_wr_raw;
  logic [31:0] ext_data;

  assign eligible = req_en & ~resp_rdy & ~(flush ? FLUSH_MASK : '0);

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PW        (PW)
  ) u_rr (
    .req       (eligible),
    .last      (rr_last),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_size   = '0;
    sel_signed = 1'b0;
    sel_write  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        sel_addr   = req_addr[32*p +: 32];
        sel_wdata  = req_wdata[32*p +: 32];
        sel_size   = req_size[2*p +: 2];
        sel_signed = req_signed[p];
        sel_write  = req_write[p];
      end
    end
  end

  assign nbytes = size_to_bytes(cur_size);
  assign rd_idx = 2'(cnt - 3'd1);

  // Only reads of flushable ports are cancelled; writes always complete.
  assign kill  = flush && FLUSH_MASK[cur_port] && !cur_write &&
                 (state == ST_RD || state == ST_DONE);
  assign stall = (state == ST_WR) && (cur_addr[17:16] == IO_HI) && io_buffer_full;

  always_comb begin
    case (cur_size)
      SZ_B:    ext_data = {{24{cur_signed & rbuf[7]}}, rbuf[7:0]};
      SZ_H:    ext_data = {{16{cur_signed & rbuf[15]}}, rbuf[15:0]};
      default: ext_data = rbuf;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= ST_IDLE;
    end else if (rdy_in) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (grant_any) state_n = sel_write ? ST_WR : ST_RD;
      ST_RD: begin
        if (kill) state_n = ST_IDLE;
        else if (cnt == nbytes) state_n = ST_DONE;
      end
      ST_WR:   if (!stall && cnt == nbytes - 3'd1) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt        <= '0;
      rr_last    <= PW'(NUM_PORTS - 1);
      cur_port   <= '0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      cur_size   <= '0;
      cur_signed <= 1'b0;
      cur_write  <= 1'b0;
      rbuf       <= '0;
      for (int p = 0; p < NUM_PORTS; p++) held[p] <= '0;
    end else if (rdy_in) begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            rr_last    <= grant_idx;
            cur_port   <= grant_idx;
            cur_addr   <= sel_addr;
            cur_wdata  <= sel_wdata;
            cur_size   <= sel_size;
            cur_signed <= sel_signed;
            cur_write  <= sel_write;
            cnt        <= '0;
            rbuf       <= '0;
          end
        end
        ST_RD: begin
          // Byte k of the read is on mem_din in the cycle after address k was issued.
          if (!kill) begin
            if (cnt != 3'd0) rbuf[{rd_idx, 3'b000} +: 8] <= mem_din;
            cnt <= cnt + 3'd1;
          end
        end
        ST_WR: begin
          if (!stall) cnt <= cnt + 3'd1;
        end
        ST_DONE: begin
          if (!kill && !cur_write) held[cur_port] <= ext_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_a      = '0;
    mem_dout   = '0;
    mem_wr_raw = 1'b0;
    resp_rdy   = '0;
    for (int p = 0; p < NUM_PORTS; p++) resp_data[32*p +: 32] = held[p];
    case (state)
      ST_RD: begin
        if (cnt < nbytes) mem_a = cur_addr + {29'd0, cnt};
      end
      ST_WR: begin
        if (!stall) begin
          mem_wr_raw = 1'b1;
          mem_a      = cur_addr + {29'd0, cnt};
          mem_dout   = cur_wdata[{cnt[1:0], 3'b000} +: 8];
        end
      end
      ST_DONE: begin
        if (rdy_in && !kill) begin
          resp_rdy[cur_port] = 1'b1;
          if (!cur_write) resp_data[32*int'(cur_port) +: 32] = ext_data;
        end
      end
      default: ;
    endcase
  end

  assign mem_wr = mem_wr_raw & rdy_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;

  localparam int N = 3;
  localparam logic [N-1:0] MASK = 3'b011;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic flush = 1'b0;
  logic io_buffer_full = 1'b0;
  logic [N-1:0]    req_en = '0;
  logic [32*N-1:0] req_addr = '0;
  logic [N-1:0]    req_write = '0;
  logic [2*N-1:0]  req_size = '0;
  logic [N-1:0]    req_signed = '0;
  logic [32*N-1:0] req_wdata = '0;
  logic [N-1:0]    resp_rdy;
  logic [32*N-1:0] resp_data;
  logic [7:0]      mem_din = '0;
  logic [7:0]      mem_dout;
  logic [31:0]     mem_a;
  logic            mem_wr;

  mem_arbiter #(.NUM_PORTS(N), .FLUSH_MASK(MASK), .IO_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .req_en(req_en), .req_addr(req_addr), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .resp_rdy(resp_rdy), .resp_data(resp_data), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] ovr [logic [31:0]];

  // Transaction-level model: one active transfer and its position on the timeline.
  bit          m_busy = 0;
  int          m_port = 0;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          m_n = 1;
  bit          m_wr = 0;
  int          m_pos = 0;
  int          m_rr = N - 1;
  logic [31:0] m_held [N];
  logic [N-1:0] last_resp = '0, last_abort = '0;
  logic [7:0]  din_next = '0;

  logic [31:0] s_a;
  logic [7:0]  s_dout;
  logic        s_wr;
  logic [N-1:0] s_resp;
  logic [31:0] s_data [N];

  function automatic logic [7:0] memf(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] read_result(input logic [31:0] a, input int n, input bit sgn);
    logic [31:0] r;
    r = {memf(a + 32'd3), memf(a + 32'd2), memf(a + 32'd1), memf(a)};
    if (n == 1) r = sgn ? {{24{r[7]}}, r[7:0]} : {24'd0, r[7:0]};
    else if (n == 2) r = sgn ? {{16{r[15]}}, r[15:0]} : {16'd0, r[15:0]};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic [31:0] ea;
    logic [7:0]  ed;
    logic        ew;
    logic [N-1:0] er;
    logic [31:0] edata [N];
    bit stall;
    bit found;
    int p;
    int sz;
    mem_din = din_next;
    #1;
    s_a = mem_a; s_dout = mem_dout; s_wr = mem_wr; s_resp = resp_rdy;
    for (int i = 0; i < N; i++) s_data[i] = resp_data[32*i +: 32];
    last_resp = '0;
    last_abort = '0;
    if (!rst_in) begin
      m_busy = 0;
      m_rr = N - 1;
      for (int i = 0; i < N; i++) m_held[i] = '0;
      din_next = '0;
    end else begin
      ea = '0; ed = '0; ew = 1'b0; er = '0; stall = 0;
      for (int i = 0; i < N; i++) edata[i] = m_held[i];
      if (m_busy) begin
        if (m_wr) begin
          stall = (m_addr[17:16] == 2'b11) && io_buffer_full;
          if (m_pos <= m_n) begin
            if (!stall) begin
              ea = m_addr + 32'(m_pos - 1);
              ed = m_wdata[8*(m_pos-1) +: 8];
              ew = rdy_in;
            end
          end else if (rdy_in) begin
            er[m_port] = 1'b1;
          end
        end else begin
          if (m_pos <= m_n) ea = m_addr + 32'(m_pos - 1);
          if (m_pos == m_n + 2 && rdy_in && !(flush && MASK[m_port])) begin
            er[m_port] = 1'b1;
            edata[m_port] = m_rdata;
          end
        end
      end
      check("mem_a", mem_a, ea);
      check("mem_wr", {31'd0, mem_wr}, {31'd0, ew});
      check("mem_dout", {24'd0, mem_dout}, {24'd0, ed});
      check("resp_rdy", {29'd0, resp_rdy}, {29'd0, er});
      for (int i = 0; i < N; i++)
        check($sformatf("resp_data%0d", i), resp_data[32*i +: 32], edata[i]);
      last_resp = er;
      if (rdy_in) begin
        if (!m_busy) begin
          found = 0;
          for (int off = 1; off <= N; off++) begin
            p = (m_rr + off) % N;
            if (!found && req_en[p] && !(flush && MASK[p])) begin
              found = 1;
              m_port = p;
              m_rr = p;
              m_addr = req_addr[32*p +: 32];
              m_wdata = req_wdata[32*p +: 32];
              sz = int'(req_size[2*p +: 2]);
              m_n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
              m_wr = req_write[p];
              m_rdata = read_result(m_addr, m_n, req_signed[p]);
              m_pos = 1;
              m_busy = 1;
            end
          end
        end else if (!m_wr) begin
          if (flush && MASK[m_port]) begin
            m_busy = 0;
            last_abort[m_port] = 1'b1;
          end else if (m_pos == m_n + 2) begin
            m_held[m_port] = m_rdata;
            m_busy = 0;
          end else begin
            m_pos++;
          end
        end else begin
          if (m_pos == m_n + 1) m_busy = 0;
          else if (!stall) m_pos++;
        end
      end
      din_next = rdy_in ? memf(mem_a) : mem_din;
    end
    @(negedge clk_in);
    cyc++;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [1:0] sz,
                         input bit wr, input bit sgn, input logic [31:0] wd);
    req_en[p] = 1'b1;
    req_addr[32*p +: 32] = a;
    req_size[2*p +: 2] = sz;
    req_write[p] = wr;
    req_signed[p] = sgn;
    req_wdata[32*p +: 32] = wd;
  endtask

  task automatic wait_resp(input int p, input string name, input logic [31:0] exp);
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (s_resp[p]) got = 1;
    end
    check({name, "_done"}, {31'd0, got}, 32'd1);
    check(name, s_data[p], exp);
    req_en[p] = 1'b0;
  endtask

  initial begin
    int order [$];
    for (int i = 0; i < N; i++) m_held[i] = '0;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (3) step();
    rst_in = 1'b1;
    step();
    check("rst_mem_a", s_a, 32'd0);
    check("rst_resp", {29'd0, s_resp}, 32'd0);
    check("rst_data1", s_data[1], 32'd0);

    ovr[32'h100] = 8'h11; ovr[32'h101] = 8'h22; ovr[32'h102] = 8'h33; ovr[32'h103] = 8'h44;
    set_req(1, 32'h100, 2'd2, 0, 0, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      check("rd4_addr", s_a, 32'h100 + 32'(k));
    end
    step();
    check("rd4_gap", {29'd0, s_resp}, 32'd0);
    step();
    check("rd4_resp", {29'd0, s_resp}, 32'd2);
    check("rd4_data", s_data[1], 32'h44332211);
    req_en[1] = 1'b0;

    ovr[32'h200] = 8'h80;
    ovr[32'h210] = 8'h01; ovr[32'h211] = 8'h80;
    set_req(0, 32'h200, 2'd0, 0, 1, 0);
    wait_resp(0, "rd1_signed", 32'hFFFFFF80);
    set_req(0, 32'h200, 2'd0, 0, 0, 0);
    wait_resp(0, "rd1_unsigned", 32'h00000080);
    set_req(0, 32'h210, 2'd1, 0, 1, 0);
    wait_resp(0, "rd2_signed", 32'hFFFF8001);

    rst_in = 1'b0;
    repeat (2) step();
    rst_in = 1'b1;
    for (int p = 0; p < N; p++) set_req(p, 32'h300 + 32'(p), 2'd0, 0, 0, 0);
    for (int i = 0; i < 60 && order.size() < 6; i++) begin
      step();
      for (int p = 0; p < N; p++) if (s_resp[p]) order.push_back(p);
    end
    check("rr_count", order.size(), 32'd6);
    for (int i = 0; i < order.size(); i++) check("rr_order", order[i], 32'(i % 3));
    req_en = '0;
    repeat (10) step();

    set_req(2, 32'h30000, 2'd0, 1, 0, 32'h41);
    io_buffer_full = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("io_stall_wr", {31'd0, s_wr}, 32'd0);
      check("io_stall_a", s_a, 32'd0);
    end
    io_buffer_full = 1'b0;
    step();
    check("io_wr", {31'd0, s_wr}, 32'd1);
    check("io_a", s_a, 32'h30000);
    check("io_dout", {24'd0, s_dout}, 32'h41);
    step();
    check("io_resp", {29'd0, s_resp}, 32'd4);
    req_en[2] = 1'b0;

    ovr[32'h600] = 8'h5C;
    set_req(0, 32'h500, 2'd2, 0, 0, 0);
    set_req(2, 32'h600, 2'd0, 0, 0, 0);
    step();
    step();
    check("fl_a0", s_a, 32'h500);
    flush = 1'b1;
    step();
    check("fl_a1", s_a, 32'h501);
    flush = 1'b0;
    req_en[0] = 1'b0;
    step();
    check("fl_idle_a", s_a, 32'd0);
    check("fl_no_resp", {29'd0, s_resp}, 32'd0);
    step();
    check("fl_next_a", s_a, 32'h600);
    wait_resp(2, "fl_p2_data", 32'h5C);

    set_req(1, 32'h400, 2'd2, 1, 0, 32'hA1B2C3D4);
    step();
    step();
    check("rdy_b0", {s_wr, 7'd0, s_dout, s_a[15:0]}, {1'b1, 7'd0, 8'hD4, 16'h0400});
    step();
    check("rdy_b1", {s_wr, 7'd0, s_dout, s_a[15:0]}, {1'b1, 7'd0, 8'hC3, 16'h0401});
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rdy_frz", {s_wr, 7'd0, s_dout, s_a[15:0]}, {1'b0, 7'd0, 8'hB2, 16'h0402});
    end
    rdy_in = 1'b1;
    step();
    check("rdy_b2", {s_wr, 7'd0, s_dout, s_a[15:0]}, {1'b1, 7'd0, 8'hB2, 16'h0402});
    step();
    check("rdy_b3", {s_wr, 7'd0, s_dout, s_a[15:0]}, {1'b1, 7'd0, 8'hA1, 16'h0403});
    step();
    check("rdy_resp", {29'd0, s_resp}, 32'd2);
    req_en[1] = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 11) == 0);
      io_buffer_full = ($urandom_range(0, 2) == 0);
      for (int p = 0; p < N; p++) begin
        if (req_en[p] && (last_resp[p] || (last_abort[p] && $urandom_range(0, 1) == 1)))
          req_en[p] = 1'b0;
        if (!req_en[p] && $urandom_range(0, 3) == 0) begin
          logic [31:0] a;
          case ($urandom_range(0, 3))
            0: a = $urandom;
            1: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            2: a = {14'd0, 2'b11, 16'($urandom)};
            default: a = 32'h100 + 32'($urandom_range(0, 255));
          endcase
          set_req(p, a, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), $urandom);
        end
      end
      step();
    end

    req_en = '0;
    rdy_in = 1'b1;
    flush = 1'b0;
    io_buffer_full = 1'b0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- N-port byte-serial memory controller: generalisation of the two-client (fetch + load/store) controller to NUM_PORTS requesters.
- Round-robin arbitration, 1/2/4-byte accesses, sign/zero-extended loads, I/O write back-pressure and per-port flush cancellation.
- Sits between the fetch, load/store and prefetch units and the external 8-bit memory bus.

Parameters:
- NUM_PORTS, 3, number of requesters; port index width PW = max(1, clog2(NUM_PORTS)).
- FLUSH_MASK, 3'b011, bit i set: port i reads are cancelled by flush.
- IO_HI, 2'b11, value of addr[17:16] that selects the I/O region.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, synchronous, active-low.
- rdy_in  in  1  global enable; low freezes all state.
- flush  in  1  mispredict flush.
- req_en  in  NUM_PORTS  request level, held until resp_rdy.
- req_addr  in  32*NUM_PORTS  byte address, port i at [32i+31:32i].
- req_write  in  NUM_PORTS  1 = write.
- req_size  in  2*NUM_PORTS  0 = 1B, 1 = 2B, 2 = 4B (3 treated as 4B).
- req_signed  in  NUM_PORTS  sign-extend read data.
- req_wdata  in  32*NUM_PORTS  write data, little-endian.
- resp_rdy  out  NUM_PORTS  one-cycle completion pulse.
- resp_data  out  32*NUM_PORTS  read result, valid with resp_rdy.
- mem_din  in  8  read byte.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART buffer full.

Behaviour:
- Reset (rst_in low at clk edge): state IDLE, all outputs 0, rr_last = NUM_PORTS-1 so port 0 wins first.
- rdy_in low: no state or output register changes; mem_wr is forced to 0 combinationally.
- States: IDLE, RD (issue/collect), WR, DONE.
- IDLE, cycle t:
  - Eligible port set = req_en, minus the port pulsing resp_rdy this cycle, minus FLUSH_MASK ports when flush is high.
  - Grant the first eligible port after rr_last, cyclically; latch its addr/size/signed/wdata; set rr_last to that port.
  - Go to RD or WR. Nothing eligible: stay in IDLE, mem_wr = 0.
- RD, n bytes:
  - mem_a = addr+k in cycles t+1..t+n; byte k arrives on mem_din one cycle later, in cycles t+2..t+n+1, placed in bits [8k+7:8k].
  - Extension: 1B/2B results sign- or zero-extended per signed.
  - resp_rdy[p] high in cycle t+n+2 (DONE) with resp_data[p]; next state IDLE.
- WR, n bytes:
  - mem_wr = 1, mem_a = addr+k, mem_dout = wdata[8k+7:8k] for k = 0..n-1.
  - I/O stall: if addr[17:16] == IO_HI and io_buffer_full is high, drive mem_wr = 0 and mem_a = 0 and do not advance k.
  - resp_rdy pulses in the cycle after the last byte.
- Address arithmetic is 32-bit wrap-around; no alignment requirement.
- resp_data[p] holds its value until port p's next completion.
- Flush:
  - A read owned by a FLUSH_MASK port aborts: mem_a = 0 from the next cycle, return to IDLE, no resp_rdy.
  - Read bytes already in flight are discarded.
  - Writes and non-masked ports are never cancelled.
  - Flush arriving in DONE for a masked read suppresses that resp_rdy.
- Idle bus: mem_a = 0, mem_dout = 0, mem_wr = 0.
- Only one transaction at a time; total latency = n + 2 cycles (read), n + 1 cycles (write), plus stalls.

Decomposition:
- Shared package mem_pkg:
  - size encoding constants SZ_B / SZ_H / SZ_W.
  - IO_ADDR_HI.
  - state encoding.
  - function size_to_bytes.
- Sub-module rr_arbiter (NUM_PORTS): combinational one-hot grant from request vector and rr_last. All other logic lives in mem_arbiter.

Test Plan:
- Reset, then port1 reads 4B at 0x100 with memory bytes 0x11,0x22,0x33,0x44 -> mem_a 0x100..0x103 in consecutive cycles; resp_rdy[1] at cycle t+6 with data 0x44332211.
- Port0 1B signed read of 0x80 -> 0xFFFFFF80; same read unsigned -> 0x00000080; 2B signed read of 0x8001 -> 0xFFFF8001.
- All three ports request continuously -> grant order 0,1,2,0,1,2; no port repeats while another waits; no duplicate grant in a resp_rdy cycle.
- Port2 writes 1B 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for 3 cycles, then one write, then resp_rdy[2].
- Port0 4B read with flush in its 2nd issue cycle -> no resp_rdy[0]; bus idle next cycle; pending port2 request granted after.
- rdy_in low for 5 cycles mid 4B write -> mem_a/mem_dout frozen, mem_wr 0; completes with correct bytes once rdy_in returns.
